dma_arbiter: RTL

- Bus-side responder for the console's DMA requesters.
- Owns the CPU bus mux and the 6502 RDY line. Grants the bus to the OAM DMA engine (oam_req/oam_active handshake) and to the DMC sample fetcher (dmc_req/dmc_ack handshake).
- Halts the CPU while a DMA owns the bus, aligns DMC fetches to APU get cycles, and returns the bus to the CPU when DMA completes.
- Sits between the CPU core, the DMA engines, and the system bus decoder.

---
 rtl/dma_arbiter_if.sv | 31 +++
 rtl/dma_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/dma_arbiter_if.sv
// Signal bundle between the DMA arbiter and the CPU core, DMA engines and bus decoder.
// The arbiter connects through the slave modport. The surrounding system connects through the master modport.
interface dma_arbiter_if;
  logic        apu_cycle;
  logic [15:0] cpu_addr_i;
  logic        cpu_rw_i;
  logic        cpu_rdy_o;
  logic        oam_req_i;
  logic [15:0] oam_addr_i;
  logic        oam_rw_i;
  logic        oam_active_o;
  logic        dmc_req_i;
  logic [15:0] dmc_addr_i;
  logic        dmc_ack_o;
  logic [7:0]  dmc_data_o;
  logic [7:0]  bus_data_i;
  logic [15:0] bus_addr_o;
  logic        bus_rw_o;

  modport slave (
    input  apu_cycle, cpu_addr_i, cpu_rw_i, oam_req_i, oam_addr_i, oam_rw_i,
           dmc_req_i, dmc_addr_i, bus_data_i,
    output cpu_rdy_o, oam_active_o, dmc_ack_o, dmc_data_o, bus_addr_o, bus_rw_o
  );

  modport master (
    output apu_cycle, cpu_addr_i, cpu_rw_i, oam_req_i, oam_addr_i, oam_rw_i,
           dmc_req_i, dmc_addr_i, bus_data_i,
    input  cpu_rdy_o, oam_active_o, dmc_ack_o, dmc_data_o, bus_addr_o, bus_rw_o
  );
endinterface

// File: rtl/dma_arbiter.sv
// Halts the 6502 and hands the CPU bus to OAM DMA or the DMC sample fetcher.
// DMC reads are aligned to APU get cycles.
module dma_arbiter (
  input  logic          clk,
  input  logic          rst,
  dma_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    OAM       = 3'd1,
    DMC_HALT  = 3'd2,
    DMC_DUMMY = 3'd3,
    DMC_GET   = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   fetch;

  // The DMC read happens only on the get half of an APU cycle.
  assign fetch = (state == DMC_GET) && bus.apu_cycle;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order
    if (rst) begin
      state            <= IDLE;
      bus.cpu_rdy_o    <= 1'b1;
      bus.oam_active_o <= 1'b0;
      bus.dmc_ack_o    <= 1'b0;
      bus.dmc_data_o   <= 8'h00;
    end else begin
      state            <= next_state;
      bus.cpu_rdy_o    <= (next_state == IDLE);
      bus.oam_active_o <= (next_state == OAM);
      bus.dmc_ack_o    <= fetch;
      if (fetch) bus.dmc_data_o <= bus.bus_data_i;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no branch can leave next_state unassigned and infer a latch
    next_state = IDLE;
    case (state)
      IDLE: begin
        // An ack cycle blocks re-entry, so a requester that drops req on ack is never fetched twice.
        if (bus.oam_req_i)                         next_state = OAM;
        else if (bus.dmc_req_i && !bus.dmc_ack_o)  next_state = DMC_HALT;
        else                                       next_state = IDLE;
      end
      OAM: begin
        // The CPU is already halted here, so a pending DMC fetch skips the halt wait.
        if (bus.oam_req_i)       next_state = OAM;
        else if (bus.dmc_req_i)  next_state = DMC_DUMMY;
        else                     next_state = IDLE;
      end
      DMC_HALT:  next_state = bus.cpu_rw_i ? DMC_DUMMY : DMC_HALT;
      DMC_DUMMY: next_state = DMC_GET;
      DMC_GET: begin
        if (!bus.apu_cycle)      next_state = DMC_GET;
        else if (bus.oam_req_i)  next_state = OAM;
        else                     next_state = IDLE;
      end
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_addr_o = bus.cpu_addr_i;
    bus.bus_rw_o   = bus.cpu_rw_i;
    if (state == OAM) begin
      bus.bus_addr_o = bus.oam_addr_i;
      bus.bus_rw_o   = bus.oam_rw_i;
    end else if (fetch) begin
      bus.bus_addr_o = bus.dmc_addr_i;
      bus.bus_rw_o   = 1'b1;
    end
  end

endmodule
